// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle sequencer for the single-issue core.
//
// It owns the program counter and steps every instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. EOF, an illegal opcode or an ALU
// overflow diverts the instruction from EXEC to HALT_PEND, then to HALT.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_i_inst         instruction word from instruction memory
//   i_alu_ovf        ALU overflow / bad data address, sampled in EXEC
//   i_alu_zero       ALU operands equal, sampled in EXEC
//   o_i_addr         current PC (instruction address)
//   o_inst           latched instruction register for the decoder
//   o_inst_valid     high in DECODE
//   o_alu_en         high in EXEC
//   o_d_re / o_d_we  data read / write strobes, held for all of MEM
//   o_rf_we          register-file write pulse in WB
//   o_rf_wsel        write-back source: 0 ALU result, 1 memory read data
//   o_status         0 R_TYPE_OK, 1 I_TYPE_OK, 2 OVERFLOW, 3 END
//   o_status_valid   one-cycle pulse per retired instruction
//   o_halt           high in HALT
//   o_state          debug view of the sequencer state
//
// There are no valid/ready handshakes on this block: every strobe is a level
// decoded from registered state, and the memories are assumed to honour the
// fixed IMEM_LAT / DMEM_LAT latencies. No input reaches an output without
// passing through a register.
module core_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int IMEM_LAT = 1,
  parameter int DMEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_i_inst,
  input  logic              i_alu_ovf,
  input  logic              i_alu_zero,
  output logic [ADDR_W-1:0] o_i_addr,
  output logic [31:0]       o_inst,
  output logic              o_inst_valid,
  output logic              o_alu_en,
  output logic              o_d_re,
  output logic              o_d_we,
  output logic              o_rf_we,
  output logic              o_rf_wsel,
  output logic [1:0]        o_status,
  output logic              o_status_valid,
  output logic              o_halt,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXEC      = 3'd3,
    S_MEM       = 3'd4,
    S_WB        = 3'd5,
    S_HALT_PEND = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam int LAT_MAX = (IMEM_LAT > DMEM_LAT) ? IMEM_LAT : DMEM_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(IMEM_LAT - 1);
  localparam logic [CNT_W-1:0] MEM_LAST   = CNT_W'(DMEM_LAT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    lat_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [31:0]         inst_q;
  logic                zero_q;

  // ---------------------------------------------------------------------
  // Opcode classification from the instruction register
  // ---------------------------------------------------------------------
  logic [5:0] opcode;
  logic       is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_eof, is_illegal;
  logic       is_branch, is_mem, writes_rf, taken;
  logic [ADDR_W-1:0] imm_sext;

  assign opcode = inst_q[31:26];

  always_comb begin
    is_r    = 1'b0;
    is_addi = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_eof  = 1'b0;
    case (opcode)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd7, 6'd8,
      6'd9, 6'd12, 6'd13, 6'd14:          is_r    = 1'b1;
      6'd4:                               is_addi = 1'b1;
      6'd5:                               is_lw   = 1'b1;
      6'd6:                               is_sw   = 1'b1;
      6'd10:                              is_beq  = 1'b1;
      6'd11:                              is_bne  = 1'b1;
      6'd15:                              is_eof  = 1'b1;
      default: ;
    endcase
  end

  // Opcodes 0..15 are all defined; anything with a bit set above that is illegal.
  assign is_illegal = (opcode[5:4] != 2'b00);
  assign is_branch  = is_beq | is_bne;
  assign is_mem     = is_lw | is_sw;
  assign writes_rf  = is_r | is_addi | is_lw;
  assign taken      = (is_beq & zero_q) | (is_bne & ~zero_q);
  assign imm_sext   = {{(ADDR_W-16){inst_q[15]}}, inst_q[15:0]};

  logic fetch_done, mem_done;
  assign fetch_done = (state_q == S_FETCH) && (lat_q == FETCH_LAST);
  assign mem_done   = (state_q == S_MEM)   && (lat_q == MEM_LAST);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (fetch_done) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // Branches only compare, so an overflow flag on them is ignored.
        if (is_eof || is_illegal || (i_alu_ovf && !is_branch))
          state_d = S_HALT_PEND;
        else if (is_mem)
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM:       if (mem_done) state_d = S_WB;
      S_WB:        state_d = S_FETCH;
      S_HALT_PEND: state_d = S_HALT;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers: latency counter, PC, instruction, zero flag
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat_q  <= '0;
      pc_q   <= '0;
      inst_q <= '0;
      zero_q <= 1'b0;
    end else begin
      // The counter is zero on entry to FETCH/MEM because every other state
      // clears it.
      if ((state_q == S_FETCH && !fetch_done) || (state_q == S_MEM && !mem_done))
        lat_q <= lat_q + 1'b1;
      else
        lat_q <= '0;

      if (fetch_done)
        inst_q <= i_i_inst;

      if (state_q == S_EXEC)
        zero_q <= i_alu_zero;

      // Modulo-2^ADDR_W arithmetic: wrap-around is intentional.
      if (state_q == S_WB)
        pc_q <= pc_q + ADDR_W'(4) + (taken ? imm_sext : '0);
    end
  end

  // ---------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------
  always_comb begin
    o_inst_valid   = (state_q == S_DECODE);
    o_alu_en       = (state_q == S_EXEC);
    o_d_re         = (state_q == S_MEM) && is_lw;
    o_d_we         = (state_q == S_MEM) && is_sw;
    o_rf_we        = (state_q == S_WB) && writes_rf;
    o_rf_wsel      = (state_q == S_WB) && is_lw;
    o_status_valid = (state_q == S_WB) || (state_q == S_HALT_PEND);
    o_halt         = (state_q == S_HALT);
    o_status       = 2'd0;
    if (state_q == S_WB)
      o_status = is_r ? 2'd0 : 2'd1;
    else if (state_q == S_HALT_PEND)
      o_status = is_eof ? 2'd3 : 2'd2;
  end

  assign o_i_addr = pc_q;
  assign o_inst   = inst_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: bench for core_ctrl.
// Main instance u_dut (IMEM_LAT = DMEM_LAT = 1) runs directed and random
// programs against a timeline model built from the retirement rules. A second
// instance u_rst (DMEM_LAT = 3) covers reset asserted in the middle of MEM.
module tb_core_ctrl;

  localparam int IL = 1;
  localparam int DL = 1;
  localparam int NC = 160;   // cycles simulated per program

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic        rst_n;
  logic [31:0] i_inst;
  logic        alu_ovf, alu_zero;
  logic [31:0] a_addr, a_inst;
  logic        a_iv, a_alu, a_re, a_we, a_rfwe, a_wsel, a_sv, a_halt;
  logic [1:0]  a_status;
  logic [2:0]  a_state;

  core_ctrl #(.ADDR_W(32), .IMEM_LAT(IL), .DMEM_LAT(DL)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_i_inst(i_inst),
    .i_alu_ovf(alu_ovf), .i_alu_zero(alu_zero),
    .o_i_addr(a_addr), .o_inst(a_inst), .o_inst_valid(a_iv), .o_alu_en(a_alu),
    .o_d_re(a_re), .o_d_we(a_we), .o_rf_we(a_rfwe), .o_rf_wsel(a_wsel),
    .o_status(a_status), .o_status_valid(a_sv), .o_halt(a_halt), .o_state(a_state)
  );

  // ---------------- reset-abort instance ----------------
  logic        b_rst_n;
  logic [31:0] b_inst_in;
  logic [31:0] b_addr, b_inst;
  logic        b_iv, b_alu, b_re, b_we, b_rfwe, b_wsel, b_sv, b_halt;
  logic [1:0]  b_status;
  logic [2:0]  b_state;

  core_ctrl #(.ADDR_W(32), .IMEM_LAT(1), .DMEM_LAT(3)) u_rst (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_i_inst(b_inst_in),
    .i_alu_ovf(1'b0), .i_alu_zero(1'b0),
    .o_i_addr(b_addr), .o_inst(b_inst), .o_inst_valid(b_iv), .o_alu_en(b_alu),
    .o_d_re(b_re), .o_d_we(b_we), .o_rf_we(b_rfwe), .o_rf_wsel(b_wsel),
    .o_status(b_status), .o_status_valid(b_sv), .o_halt(b_halt), .o_state(b_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int cyc,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- program memory / per-instruction ALU flags ----------------
  logic [31:0] imem   [logic [31:0]];
  bit          ovf_m  [logic [31:0]];
  bit          zero_m [logic [31:0]];

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w, input bit ov, input bit zr);
    imem[a]   = w;
    ovf_m[a]  = ov;
    zero_m[a] = zr;
  endtask

  task automatic clear_prog();
    imem.delete();
    ovf_m.delete();
    zero_m.delete();
  endtask

  task automatic gen_rand(input logic [31:0] a);
    logic [5:0]  op;
    logic [15:0] imm;
    int          sel, off;
    logic [5:0]  legal [15];
    legal = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd7, 6'd8, 6'd9, 6'd12, 6'd13, 6'd14,
              6'd4, 6'd5, 6'd6, 6'd10, 6'd11};
    sel = int'($urandom_range(0, 99));
    if (sel < 4)       op = 6'd15;
    else if (sel < 7)  op = 6'($urandom_range(16, 63));
    else               op = legal[$urandom_range(0, 14)];
    off = int'($urandom_range(0, 12)) * 4 - 24;
    imm = off[15:0];
    put(a, {op, 10'($urandom), imm}, ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)));
  endtask

  // ---------------- expected timeline ----------------
  logic [31:0] e_addr [NC+8];
  logic [31:0] e_inst [NC+8];
  logic [1:0]  e_st   [NC+8];
  bit e_iv [NC+8], e_alu [NC+8], e_re [NC+8], e_we [NC+8];
  bit e_rfwe [NC+8], e_wsel [NC+8], e_sv [NC+8], e_halt [NC+8];

  // Walks the program one instruction at a time. An instruction whose fetch
  // starts in sample cycle t spends IL cycles fetching, one decoding, one
  // executing, DL in memory (loads/stores only), and retires in the next.
  task automatic build_expect();
    logic [31:0] pc, inst, sext;
    logic [5:0]  op;
    bit is_r, eof, ill, lw, sw, addi, br, taken, err, ov, zr;
    int t, dec, exe, r, memc;
    bit done;
    for (int c = 0; c < NC + 8; c++) begin
      e_addr[c] = '0; e_inst[c] = '0; e_st[c] = '0;
      e_iv[c] = 0; e_alu[c] = 0; e_re[c] = 0; e_we[c] = 0;
      e_rfwe[c] = 0; e_wsel[c] = 0; e_sv[c] = 0; e_halt[c] = 0;
    end
    pc = '0;
    t = 1;
    done = 0;
    while (!done && t < NC) begin
      if (!imem.exists(pc)) gen_rand(pc);
      inst = imem[pc];
      ov   = ovf_m[pc];
      zr   = zero_m[pc];
      op   = inst[31:26];
      sext = {{16{inst[15]}}, inst[15:0]};
      is_r = op inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd7, 6'd8, 6'd9, 6'd12, 6'd13, 6'd14};
      addi = (op == 6'd4);
      lw   = (op == 6'd5);
      sw   = (op == 6'd6);
      br   = (op == 6'd10) || (op == 6'd11);
      eof  = (op == 6'd15);
      ill  = (op >= 6'd16);
      taken = ((op == 6'd10) && zr) || ((op == 6'd11) && !zr);
      err  = eof || ill || (ov && !br);
      dec  = t + IL;
      exe  = dec + 1;
      for (int c = t; c <= exe; c++) e_addr[c] = pc;
      e_iv[dec]   = 1;
      e_inst[dec] = inst;
      e_alu[exe]  = 1;
      if (err) begin
        r = exe + 1;
        e_addr[r] = pc;
        e_sv[r]   = 1;
        e_st[r]   = eof ? 2'd3 : 2'd2;
        for (int c = r + 1; c < NC; c++) begin
          e_addr[c] = pc;
          e_halt[c] = 1;
        end
        done = 1;
      end else begin
        memc = (lw || sw) ? DL : 0;
        for (int c = exe + 1; c <= exe + memc; c++) begin
          e_addr[c] = pc;
          e_re[c]   = lw;
          e_we[c]   = sw;
        end
        r = exe + 1 + memc;
        e_addr[r] = pc;
        e_sv[r]   = 1;
        e_st[r]   = is_r ? 2'd0 : 2'd1;
        e_rfwe[r] = is_r || addi || lw;
        e_wsel[r] = lw;
        pc = pc + 32'd4 + (taken ? sext : 32'd0);
        t  = r + 1;
      end
    end
  endtask

  // Instruction memory and ALU flag responses for the instruction at o_i_addr.
  task automatic drive_inputs();
    logic [31:0] a;
    a = a_addr;
    if (imem.exists(a)) begin
      i_inst   = imem[a];
      alu_ovf  = ovf_m[a];
      alu_zero = zero_m[a];
    end else begin
      i_inst   = 32'hFC00_0000;
      alu_ovf  = 1'b0;
      alu_zero = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    i_inst   = '0;
    alu_ovf  = 1'b0;
    alu_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr",   0, a_addr, 32'd0);
    chk("rst_inst",   0, a_inst, 32'd0);
    chk("rst_strobe", 0, {27'd0, a_iv, a_alu, a_re, a_we, a_rfwe}, 32'd0);
    chk("rst_status", 0, {29'd0, a_sv, a_status}, 32'd0);
    chk("rst_halt",   0, 32'(a_halt), 32'd0);
    rst_n = 1'b1;
    drive_inputs();
  endtask

  task automatic run_prog(input string name);
    build_expect();
    do_reset();
    for (int k = 1; k < NC; k++) begin
      @(posedge clk);
      #1;
      chk({name, ":addr"},  k, a_addr, e_addr[k]);
      chk({name, ":iv"},    k, 32'(a_iv),   32'(e_iv[k]));
      chk({name, ":alu"},   k, 32'(a_alu),  32'(e_alu[k]));
      chk({name, ":d_re"},  k, 32'(a_re),   32'(e_re[k]));
      chk({name, ":d_we"},  k, 32'(a_we),   32'(e_we[k]));
      chk({name, ":rf_we"}, k, 32'(a_rfwe), 32'(e_rfwe[k]));
      chk({name, ":sv"},    k, 32'(a_sv),   32'(e_sv[k]));
      chk({name, ":halt"},  k, 32'(a_halt), 32'(e_halt[k]));
      if (e_iv[k]) chk({name, ":inst"}, k, a_inst, e_inst[k]);
      if (e_sv[k]) chk({name, ":status"}, k, 32'(a_status), 32'(e_st[k]));
      if (e_rfwe[k]) chk({name, ":wsel"}, k, 32'(a_wsel), 32'(e_wsel[k]));
      drive_inputs();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    b_rst_n   = 1'b0;
    b_inst_in = mk(6'd5, 16'd0);   // LW forever on the reset-abort instance
    i_inst    = '0;
    alu_ovf   = 1'b0;
    alu_zero  = 1'b0;

    // Reset asserted during MEM of a LW with DMEM_LAT = 3.
    repeat (3) @(posedge clk);
    #1;
    b_rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk("mid_pre_re", k, 32'(b_re), 32'(k == 4));
      chk("mid_pre_sv", k, 32'(b_sv), 32'd0);
    end
    #2;
    b_rst_n = 1'b0;
    #1;
    chk("mid_abort_re",   0, 32'(b_re),  32'd0);
    chk("mid_abort_sv",   0, 32'(b_sv),  32'd0);
    chk("mid_abort_addr", 0, b_addr,     32'd0);
    @(posedge clk);
    #1;
    b_rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      chk("mid_rs_addr", k, b_addr, 32'd0);
      chk("mid_rs_re",   k, 32'(b_re), 32'(k >= 4 && k <= 6));
      chk("mid_rs_sv",   k, 32'(b_sv), 32'(k == 7));
      if (k == 7) begin
        chk("mid_rs_status", k, 32'(b_status), 32'd1);
        chk("mid_rs_rfwe",   k, 32'(b_rfwe),   32'd1);
        chk("mid_rs_wsel",   k, 32'(b_wsel),   32'd1);
      end
    end

    // R-type then EOF.
    clear_prog();
    put(32'h0, mk(6'd0,  16'd0), 0, 0);
    put(32'h4, mk(6'd15, 16'd0), 0, 0);
    run_prog("r_eof");

    // LW, SW, EOF.
    clear_prog();
    put(32'h0, mk(6'd5,  16'd0), 0, 0);
    put(32'h4, mk(6'd6,  16'd0), 0, 0);
    put(32'h8, mk(6'd15, 16'd0), 0, 0);
    run_prog("lw_sw");

    // Branches and PC wrap-around.
    clear_prog();
    put(32'h0000_0000, mk(6'd10, 16'd12),     0, 1);  // BEQ taken -> 0x10
    put(32'h0000_0010, mk(6'd10, 16'd8),      0, 1);  // BEQ taken -> 0x1C
    put(32'h0000_001C, mk(6'd11, 16'd8),      0, 1);  // BNE not taken -> 0x20
    put(32'h0000_0020, mk(6'd10, 16'hFFD8),   0, 1);  // BEQ taken -> 0xFFFF_FFFC
    put(32'hFFFF_FFFC, mk(6'd0,  16'd0),      0, 0);  // R-type, PC wraps to 0
    run_prog("branch");

    // Errors.
    clear_prog();
    put(32'h0, mk(6'd4, 16'd1), 1, 0);
    run_prog("addi_ovf");
    clear_prog();
    put(32'h0, mk(6'd6, 16'd0), 1, 0);
    run_prog("sw_ovf");
    clear_prog();
    put(32'h0, mk(6'd20, 16'd0), 0, 0);
    run_prog("illegal");

    // Random programs.
    for (int p = 0; p < 8; p++) begin
      clear_prog();
      run_prog("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle sequencer for the single-issue core. It owns the program counter, steps every instruction through fetch, decode, execute, memory and write-back, and drives the instruction-memory address, data-memory strobes and register-file write enable. It emits one status code per retired instruction and halts on end-of-program or error. It sits between the memories and the decoder/ALU/register-file datapath.

## Interface
- ADDR_W, 32: PC and instruction-address width.
- IMEM_LAT, 1: cycles from `o_i_addr` change to valid `i_i_inst` (≥1).
- DMEM_LAT, 1: cycles a data-memory access occupies (≥1).
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_i_inst  in  32  instruction word from instruction memory.
- i_alu_ovf  in  1  ALU overflow or out-of-range data address, valid in EXEC.
- i_alu_zero  in  1  ALU operands equal, valid in EXEC.
- o_i_addr  out  ADDR_W  current PC.
- o_inst  out  32  latched instruction register feeding the decoder.
- o_inst_valid  out  1  high in DECODE.
- o_alu_en  out  1  high in EXEC.
- o_d_re / o_d_we  out  1 each  data read/write strobes, held for all of MEM.
- o_rf_we  out  1  one-cycle register-file write pulse in WB.
- o_rf_wsel  out  1  0 = ALU result, 1 = memory read data.
- o_status  out  2  0 R_TYPE_OK, 1 I_TYPE_OK, 2 OVERFLOW, 3 END.
- o_status_valid  out  1  one-cycle pulse per retired instruction.
- o_halt  out  1  high in HALT.

## Operation
- Opcode is `o_inst[31:26]`. R-type: 0,1,2,3,7,8,9,12,13,14. I-type: 4 ADDI, 5 LW, 6 SW, 10 BEQ, 11 BNE. 15 is EOF. Every opcode ≥16 is illegal.
- The immediate `o_inst[15:0]` is sign-extended to ADDR_W.
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: lasts IMEM_LAT cycles, counted by the latency counter. `o_inst` loads from `i_i_inst` on the last FETCH edge, then DECODE.
  - DECODE: one cycle, then EXEC.
  - EXEC: one cycle; `i_alu_ovf` and `i_alu_zero` are sampled. Next state is HALT_PEND for EOF, illegal opcode or overflow; MEM for LW/SW; WB otherwise.
  - MEM: lasts DMEM_LAT cycles, counted by the latency counter, then WB.
  - WB: one cycle. Pulses `o_status_valid` and updates the PC, then FETCH.
  - HALT_PEND: one cycle; pulses `o_status_valid` with 3 for EOF and 2 for overflow or illegal opcode, then HALT.
  - HALT: absorbing. All strobes stay low. Only reset leaves it.
- Write-back:
  - `o_rf_we` = 1 in WB for R-type, ADDI and LW.
  - `o_rf_wsel` = 1 only for LW.
  - SW, BEQ and BNE never write the register file.
- Status in WB: 0 for R-type, 1 for I-type.
- PC update in WB:
  - Branch is taken when (BEQ and zero) or (BNE and not zero).
  - Taken: PC ← PC + 4 + sext(imm).
  - Otherwise: PC ← PC + 4.
  - Arithmetic is modulo 2^ADDR_W; wrap-around is silent and is not an error.
- Overflow on LW/SW: MEM is skipped. No `o_d_re`/`o_d_we` assertion and no register write occur.
- Overflow on a branch is ignored; branches only compare.

## Timing
- Reset values: PC = 0, `o_inst` = 0, state IDLE, all strobes 0, `o_status` = 0, `o_status_valid` = 0, `o_halt` = 0.
- Outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Cycles per instruction:
  - non-memory: IMEM_LAT + 3
  - LW/SW: IMEM_LAT + DMEM_LAT + 3
  - EOF/error: IMEM_LAT + 3, then HALT.
- `o_i_addr` is stable for all of FETCH. It changes only on the WB→FETCH edge.
- `o_status`/`o_status_valid` are asserted in the same cycle and are valid only while `o_status_valid` = 1.
- Reset asserted mid-instruction aborts immediately:
  - no pending strobe completes;
  - PC returns to 0;
  - the next program starts from IDLE.

## Test plan
- Reset/idle: hold `i_rst_n` = 0 for 3 cycles, then release → `o_i_addr` = 0, all strobes 0, FETCH entered on the second cycle after release.
- R-type then EOF (IMEM_LAT = DMEM_LAT = 1): opcode 0 at addr 0, opcode 15 at addr 4 →
  - status 0 valid at cycle 4 with `o_rf_we` = 1;
  - PC = 4;
  - status 3 at cycle 8;
  - `o_halt` stays 1 afterwards.
- LW/SW: LW at addr 0, SW at addr 4 →
  - each has a 1-cycle MEM (`o_d_re`, then `o_d_we`) and retires in 5 cycles;
  - LW has `o_rf_we` = 1, `o_rf_wsel` = 1;
  - SW has no rf write;
  - status 1 for both.
- Branches: BEQ imm = 8 at addr 0x10 with zero = 1 → next `o_i_addr` = 0x1C. BNE with zero = 1 → 0x14. PC = 0xFFFF_FFFC with no branch → wraps to 0.
- Errors: ADDI with `i_alu_ovf` = 1 → no `o_rf_we`, status 2, halt. SW with overflow → `o_d_we` never asserted, status 2. Opcode 20 → status 2.
- Reset mid-MEM: assert reset during the LW MEM cycle (DMEM_LAT = 3) → `o_d_re` drops asynchronously, no status pulse, and the core restarts at PC 0.
